// File: rtl/alu_ctrl_dmem.sv
// -----------------------------------------------------------------------------
// alu_ctrl_dmem
// Execute/memory stage of the single-cycle RV32I core. It decodes the current
// instruction, drives a 10-operation ALU, resolves branches and jumps, and
// performs byte/half/word loads and stores to a local little-endian data RAM.
//
// Parameters
//   DMEM_WORDS   data RAM depth in 32-bit words (power of two)
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous, active-low reset (clears the RAM)
//   instr        in   32  current instruction
//   pc           in   32  address of instr
//   rs1_data     in   32  register file read port 1
//   rs2_data     in   32  register file read port 2
//   imm          in   32  sign-extended immediate for instr's format
//   alu_out      out  32  ALU result, also the data memory byte address
//   wb_data      out  32  value to write to rd
//   reg_wen      out  1   rd write enable
//   pc_redirect  out  1   taken branch, jal or jalr
//   pc_target    out  32  next PC when pc_redirect is set
// -----------------------------------------------------------------------------
module alu_ctrl_dmem #(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic [31:0] alu_out,
  output logic [31:0] wb_data,
  output logic        reg_wen,
  output logic        pc_redirect,
  output logic [31:0] pc_target
);

  localparam int AW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_sel_e;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        unused_instr_bits;

  alu_sel_e    alu_sel;
  logic        use_imm;
  logic        pc_as_a;
  logic        wen_dec;
  logic        store_en;
  logic        is_load;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic        br_taken;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;

  logic [31:0]   mem [DMEM_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [31:0]   byte_lane;
  logic [15:0]   half_lane;
  logic [31:0]   load_data;
  logic [31:0]   wr_mask;
  logic [31:0]   wr_data;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];

  // Register specifiers and the rest of funct7 are consumed elsewhere in the core.
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // funct3 maps onto the ALU the same way for OP and OP-IMM; only register-register
  // ops may turn add into sub, because addi's bit 30 belongs to its immediate.
  function automatic alu_sel_e arith_sel(input logic [2:0] f3, input logic alt,
                                         input logic allow_sub);
    case (f3)
      3'd0:    arith_sel = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'd1:    arith_sel = ALU_SLL;
      3'd2:    arith_sel = ALU_SLT;
      3'd3:    arith_sel = ALU_SLTU;
      3'd4:    arith_sel = ALU_XOR;
      3'd5:    arith_sel = alt ? ALU_SRA : ALU_SRL;
      3'd6:    arith_sel = ALU_OR;
      default: arith_sel = ALU_AND;
    endcase
  endfunction

  // Instruction decode: class flags, ALU selection and operand routing.
  // Illegal funct3 values for load/store/branch/jalr leave every flag clear so the
  // instruction has no architectural effect.
  always_comb begin
    alu_sel   = ALU_ADD;
    use_imm   = 1'b0;
    pc_as_a   = 1'b0;
    wen_dec   = 1'b0;
    store_en  = 1'b0;
    is_load   = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OPC_OP: begin
        wen_dec = 1'b1;
        alu_sel = arith_sel(funct3, funct7b5, 1'b1);
      end
      OPC_OPIMM: begin
        wen_dec = 1'b1;
        use_imm = 1'b1;
        alu_sel = arith_sel(funct3, funct7b5, 1'b0);
      end
      OPC_LOAD: begin
        use_imm = 1'b1;
        is_load = (funct3 != 3'd3) && (funct3 < 3'd6);
        wen_dec = is_load;
      end
      OPC_STORE: begin
        use_imm  = 1'b1;
        store_en = (funct3 < 3'd3);
      end
      OPC_BRANCH: begin
        is_branch = (funct3[2:1] != 2'b01);
      end
      OPC_JAL: begin
        is_jal  = 1'b1;
        wen_dec = 1'b1;
      end
      OPC_JALR: begin
        use_imm = 1'b1;
        is_jalr = (funct3 == 3'd0);
        wen_dec = is_jalr;
      end
      OPC_LUI: begin
        wen_dec = 1'b1;
      end
      OPC_AUIPC: begin
        use_imm = 1'b1;
        pc_as_a = 1'b1;
        wen_dec = 1'b1;
      end
      default: ;
    endcase
  end

  assign op_a  = pc_as_a ? pc : rs1_data;
  assign op_b  = use_imm ? imm : rs2_data;
  assign shamt = op_b[4:0];

  // The ALU proper; unused select codes produce zero.
  always_comb begin
    alu_out = 32'd0;
    case (alu_sel)
      ALU_ADD:  alu_out = op_a + op_b;
      ALU_SUB:  alu_out = op_a - op_b;
      ALU_SLL:  alu_out = op_a << shamt;
      ALU_SLT:  alu_out = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      ALU_SLTU: alu_out = (op_a < op_b) ? 32'd1 : 32'd0;
      ALU_XOR:  alu_out = op_a ^ op_b;
      ALU_SRL:  alu_out = op_a >> shamt;
      ALU_SRA:  alu_out = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   alu_out = op_a | op_b;
      ALU_AND:  alu_out = op_a & op_b;
      default:  alu_out = 32'd0;
    endcase
  end

  // Branch condition, compared directly on the register values rather than
  // through the ALU so the ALU stays free for the address/result path.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'd0:    br_taken = (rs1_data == rs2_data);
      3'd1:    br_taken = (rs1_data != rs2_data);
      3'd4:    br_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'd5:    br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'd6:    br_taken = (rs1_data <  rs2_data);
      3'd7:    br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  // jalr's ALU result is rs1+imm; its target drops bit 0. Everything else
  // that redirects is PC-relative.
  assign pc_target   = is_jalr ? (alu_out & 32'hFFFF_FFFE) : (pc + imm);
  assign pc_redirect = rst && (is_jal || is_jalr || (is_branch && br_taken));
  assign reg_wen     = rst && wen_dec;

  // Word addressing ignores the low two bits and any bits above the RAM depth.
  assign word_idx = alu_out[AW+1:2];
  assign rd_word  = mem[word_idx];

  // Load lane extraction: bytes by addr[1:0], halves by addr[1], words whole.
  always_comb begin
    byte_lane = rd_word >> {alu_out[1:0], 3'b000};
    half_lane = alu_out[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'd0;
    case (funct3)
      3'd0:    load_data = {{24{byte_lane[7]}}, byte_lane[7:0]};
      3'd1:    load_data = {{16{half_lane[15]}}, half_lane};
      3'd2:    load_data = rd_word;
      3'd4:    load_data = {24'd0, byte_lane[7:0]};
      3'd5:    load_data = {16'd0, half_lane};
      default: load_data = 32'd0;
    endcase
  end

  // Store lane mask and replicated data; only masked lanes change, so a partial
  // store is a read-modify-write of the addressed word.
  always_comb begin
    wr_mask = 32'hFFFF_FFFF;
    wr_data = rs2_data;
    case (funct3[1:0])
      2'd0: begin
        wr_mask = 32'h0000_00FF << {alu_out[1:0], 3'b000};
        wr_data = {4{rs2_data[7:0]}};
      end
      2'd1: begin
        wr_mask = alu_out[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wr_data = {2{rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Data RAM: reset wipes every word immediately and blocks stores while held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (store_en) begin
      mem[word_idx] <= (rd_word & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  // Write-back source selection.
  always_comb begin
    wb_data = alu_out;
    case (opcode)
      OPC_LUI:   wb_data = imm;
      OPC_AUIPC: wb_data = pc + imm;
      OPC_JAL:   wb_data = pc + 32'd4;
      OPC_JALR:  wb_data = pc + 32'd4;
      OPC_LOAD:  wb_data = load_data;
      default:   wb_data = alu_out;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_dmem.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_dmem
// Self-checking bench for alu_ctrl_dmem. A byte-addressed reference memory and
// an instruction-level model predict every output; a compare process checks the
// DUT on each falling clock edge, and a directed sequence pins known results.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_dmem;

  localparam int DMEM_WORDS = 256;
  localparam int MEM_BYTES  = DMEM_WORDS * 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic [31:0] wb_data;
  logic        reg_wen;
  logic        pc_redirect;
  logic [31:0] pc_target;

  int errors = 0;
  int checks = 0;
  bit run_check = 1'b0;

  logic [7:0] model_mem [MEM_BYTES];

  alu_ctrl_dmem #(.DMEM_WORDS(DMEM_WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .pc          (pc),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm         (imm),
    .alu_out     (alu_out),
    .wb_data     (wb_data),
    .reg_wen     (reg_wen),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Instruction word with given opcode/funct3/bit30 and random filler elsewhere.
  function automatic logic [31:0] mkInstr(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic alt);
    logic [31:0] w;
    w = $urandom & 32'hBFFF_8F80;
    w[30]    = alt;
    w[14:12] = f3;
    w[6:0]   = opc;
    return w;
  endfunction

  // Reference arithmetic by RV32I mnemonic.
  function automatic logic [31:0] modelArith(input logic [2:0] f3, input logic sub_en,
                                             input logic sra_en, input logic [31:0] a,
                                             input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (f3)
      3'd0:    return sub_en ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return sra_en ? $unsigned($signed(a) >>> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Reference load from the byte-addressed model memory (address wraps at its size).
  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned a;
    int unsigned wb;
    int unsigned hb;
    logic [31:0] word;
    logic [15:0] half;
    logic [7:0]  b;
    a    = addr % MEM_BYTES;
    wb   = a - (a % 4);
    hb   = a - (a % 2);
    word = {model_mem[wb+3], model_mem[wb+2], model_mem[wb+1], model_mem[wb]};
    half = {model_mem[hb+1], model_mem[hb]};
    b    = model_mem[a];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{half[15]}}, half};
      3'd2:    return word;
      3'd4:    return {24'd0, b};
      default: return {16'd0, half};
    endcase
  endfunction

  // Model memory update at each rising edge for a legal store while out of reset.
  always @(posedge clk) begin
    if (rst === 1'b1 && instr[6:0] == OPC_STORE && instr[14:12] < 3'd3) begin
      int unsigned a;
      a = (rs1_data + imm) % MEM_BYTES;
      case (instr[14:12])
        3'd0: model_mem[a] = rs2_data[7:0];
        3'd1: begin
          a = a - (a % 2);
          model_mem[a]   = rs2_data[7:0];
          model_mem[a+1] = rs2_data[15:8];
        end
        default: begin
          a = a - (a % 4);
          for (int k = 0; k < 4; k++) model_mem[a+k] = rs2_data[8*k +: 8];
        end
      endcase
    end
  end

  // Reset empties the model memory at once.
  always @(negedge rst) begin
    for (int k = 0; k < MEM_BYTES; k++) model_mem[k] = 8'd0;
  end

  // Predicts all outputs for the current inputs and compares those that are defined.
  task automatic checkOutput();
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] exp_alu, exp_wb, exp_tgt;
    logic        exp_wen, exp_redir, taken;
    bit          chk_alu, chk_wb;
    opc = instr[6:0];
    f3  = instr[14:12];
    alt = instr[30];
    exp_alu = 32'd0; exp_wb = 32'd0; exp_tgt = 32'd0;
    exp_wen = 1'b0; exp_redir = 1'b0; taken = 1'b0;
    chk_alu = 1'b0; chk_wb = 1'b0;
    case (opc)
      OPC_OP: begin
        exp_alu = modelArith(f3, alt, alt, rs1_data, rs2_data);
        exp_wb = exp_alu; exp_wen = 1'b1; chk_alu = 1'b1; chk_wb = 1'b1;
      end
      OPC_OPIMM: begin
        exp_alu = modelArith(f3, 1'b0, alt, rs1_data, imm);
        exp_wb = exp_alu; exp_wen = 1'b1; chk_alu = 1'b1; chk_wb = 1'b1;
      end
      OPC_LOAD: begin
        exp_alu = rs1_data + imm; chk_alu = 1'b1;
        if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
          exp_wen = 1'b1; exp_wb = modelLoad(f3, exp_alu); chk_wb = 1'b1;
        end
      end
      OPC_STORE: begin
        exp_alu = rs1_data + imm; chk_alu = 1'b1;
      end
      OPC_BRANCH: begin
        case (f3)
          3'd0: taken = (rs1_data == rs2_data);
          3'd1: taken = (rs1_data != rs2_data);
          3'd4: taken = ($signed(rs1_data) <  $signed(rs2_data));
          3'd5: taken = ($signed(rs1_data) >= $signed(rs2_data));
          3'd6: taken = (rs1_data <  rs2_data);
          3'd7: taken = (rs1_data >= rs2_data);
          default: taken = 1'b0;
        endcase
        exp_redir = taken; exp_tgt = pc + imm;
      end
      OPC_JAL: begin
        exp_wen = 1'b1; exp_redir = 1'b1; exp_tgt = pc + imm;
        exp_wb = pc + 32'd4; chk_wb = 1'b1;
      end
      OPC_JALR: begin
        exp_alu = rs1_data + imm; chk_alu = 1'b1;
        if (f3 == 3'd0) begin
          exp_wen = 1'b1; exp_redir = 1'b1;
          exp_tgt = {exp_alu[31:1], 1'b0};
          exp_wb = pc + 32'd4; chk_wb = 1'b1;
        end
      end
      OPC_LUI: begin
        exp_wen = 1'b1; exp_wb = imm; chk_wb = 1'b1;
      end
      OPC_AUIPC: begin
        exp_wen = 1'b1; exp_wb = pc + imm; chk_wb = 1'b1;
      end
      default: ;
    endcase
    if (rst !== 1'b1) begin
      exp_wen = 1'b0;
      exp_redir = 1'b0;
    end
    check("reg_wen", {31'd0, reg_wen}, {31'd0, exp_wen});
    check("pc_redirect", {31'd0, pc_redirect}, {31'd0, exp_redir});
    if (chk_alu) check("alu_out", alu_out, exp_alu);
    if (chk_wb) check("wb_data", wb_data, exp_wb);
    if (exp_redir) check("pc_target", pc_target, exp_tgt);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run_check) checkOutput();
  end

  // Drives one instruction just after a rising edge.
  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] im);
    @(posedge clk);
    #1;
    instr = i; pc = p; rs1_data = r1; rs2_data = r2; imm = im;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  logic [6:0] opc_table [10];

  // Directed sequence with literal expectations, then a randomized run.
  initial begin
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] r1, r2, im;

    opc_table = '{OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                  OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, 7'b1111111};

    rst = 1'b1;
    instr = mkInstr(OPC_LUI, 3'd0, 1'b0);
    pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0; imm = 32'h0000_7000;
    #3 rst = 1'b0;
    run_check = 1'b1;

    // Reset state: writes and redirects suppressed, combinational paths live.
    settle();
    check("reset reg_wen", {31'd0, reg_wen}, 32'd0);
    check("reset lui wb_data", wb_data, 32'h0000_7000);
    applyStimulus(mkInstr(OPC_JAL, 3'd0, 1'b0), 32'h40, 32'd0, 32'd0, 32'h10);
    settle();
    check("reset pc_redirect", {31'd0, pc_redirect}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // ALU basics.
    applyStimulus(mkInstr(OPC_OP, 3'd0, 1'b0), 32'h0, 32'd7, 32'd5, 32'd0);
    settle();
    check("add", alu_out, 32'd12);
    check("add reg_wen", {31'd0, reg_wen}, 32'd1);
    applyStimulus(mkInstr(OPC_OP, 3'd0, 1'b1), 32'h0, 32'd7, 32'd5, 32'd0);
    settle();
    check("sub", alu_out, 32'd2);
    applyStimulus(mkInstr(OPC_OP, 3'd3, 1'b0), 32'h0, 32'd5, 32'd7, 32'd0);
    settle();
    check("sltu", alu_out, 32'd1);
    applyStimulus(mkInstr(OPC_OP, 3'd5, 1'b1), 32'h0, 32'hFFFF_FFF0, 32'd2, 32'd0);
    settle();
    check("sra", alu_out, 32'hFFFF_FFFC);

    // Word store, then loads of several widths.
    applyStimulus(mkInstr(OPC_STORE, 3'd2, 1'b0), 32'h0, 32'd8, 32'hAABB_CCDD, 32'd0);
    applyStimulus(mkInstr(OPC_LOAD, 3'd2, 1'b0), 32'h0, 32'd8, 32'd0, 32'd0);
    settle();
    check("lw @8", wb_data, 32'hAABB_CCDD);
    applyStimulus(mkInstr(OPC_LOAD, 3'd0, 1'b0), 32'h0, 32'd9, 32'd0, 32'd0);
    settle();
    check("lb @9", wb_data, 32'hFFFF_FFCC);
    applyStimulus(mkInstr(OPC_LOAD, 3'd5, 1'b0), 32'h0, 32'd10, 32'd0, 32'd0);
    settle();
    check("lhu @10", wb_data, 32'h0000_AABB);

    // Byte store into the middle of that word.
    applyStimulus(mkInstr(OPC_STORE, 3'd0, 1'b0), 32'h0, 32'd9, 32'h0000_0011, 32'd0);
    settle();
    check("sb reg_wen", {31'd0, reg_wen}, 32'd0);
    applyStimulus(mkInstr(OPC_LOAD, 3'd2, 1'b0), 32'h0, 32'd8, 32'd0, 32'd0);
    settle();
    check("lw after sb", wb_data, 32'hAABB_11DD);

    // Branches and jumps.
    applyStimulus(mkInstr(OPC_BRANCH, 3'd0, 1'b0), 32'h40, 32'd3, 32'd3, 32'hFFFF_FFF8);
    settle();
    check("beq redirect", {31'd0, pc_redirect}, 32'd1);
    check("beq target", pc_target, 32'h38);
    applyStimulus(mkInstr(OPC_BRANCH, 3'd1, 1'b0), 32'h40, 32'd3, 32'd3, 32'hFFFF_FFF8);
    settle();
    check("bne redirect", {31'd0, pc_redirect}, 32'd0);
    applyStimulus(mkInstr(OPC_JALR, 3'd0, 1'b0), 32'h100, 32'h205, 32'd0, 32'd0);
    settle();
    check("jalr target", pc_target, 32'h204);
    check("jalr wb_data", wb_data, 32'h104);
    applyStimulus(mkInstr(OPC_LUI, 3'd0, 1'b0), 32'h0, 32'd0, 32'd0, 32'h1234_5000);
    settle();
    check("lui wb_data", wb_data, 32'h1234_5000);

    // Mid-run reset wipes memory immediately and blocks stores while held.
    applyStimulus(mkInstr(OPC_STORE, 3'd2, 1'b0), 32'h0, 32'h20, 32'h1234_5678, 32'd0);
    applyStimulus(mkInstr(OPC_LOAD, 3'd2, 1'b0), 32'h0, 32'h20, 32'd0, 32'd0);
    settle();
    check("lw @0x20", wb_data, 32'h1234_5678);
    @(posedge clk);
    #1 rst = 1'b0;
    settle();
    check("lw @0x20 in reset", wb_data, 32'd0);
    check("lw reg_wen in reset", {31'd0, reg_wen}, 32'd0);
    applyStimulus(mkInstr(OPC_STORE, 3'd2, 1'b0), 32'h0, 32'h8, 32'hDEAD_BEEF, 32'd0);
    applyStimulus(mkInstr(OPC_LOAD, 3'd2, 1'b0), 32'h0, 32'h8, 32'd0, 32'd0);
    rst = 1'b1;
    settle();
    check("lw @8 after reset", wb_data, 32'd0);

    // Randomized run; addresses cluster in a small window so loads hit earlier stores.
    for (int n = 0; n < 800; n++) begin
      opc = opc_table[$urandom_range(0, 9)];
      f3  = 3'($urandom_range(0, 7));
      if (opc == OPC_LOAD || opc == OPC_STORE) begin
        r1 = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
        im = 32'($urandom_range(0, 31)) - 32'd16;
      end else begin
        r1 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
        im = $urandom;
      end
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      applyStimulus(mkInstr(opc, f3, 1'($urandom_range(0, 1))), $urandom & 32'hFFFF_FFFC,
                    r1, r2, im);
      rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
    end

    settle();
    run_check = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
